// File: rtl/scoreboard_mp_pkg.sv
// Shared scoreboard definitions: default field widths, entry layout
// offsets and functional-unit tag values.
package scoreboard_defs;

    localparam int DEF_UNIT_W = 2;
    localparam int DEF_POS_W  = 5;

    localparam int ENTRY_W  = 1 + DEF_UNIT_W + DEF_POS_W;
    localparam int POS_LSB  = 0;
    localparam int UNIT_LSB = DEF_POS_W;
    localparam int PEND_BIT = DEF_POS_W + DEF_UNIT_W;

    typedef enum logic [1:0] {
        ALU = 2'd0,
        MEM = 2'd1,
        MUL = 2'd2,
        BR  = 2'd3
    } unit_e;

endpackage

// File: rtl/scoreboard_mp_entry.sv
// sb_entry: one scoreboard register entry (pending, owning unit, one-hot
// result position). Ports: clock/reset, wr_en/wr_unit/wr_pos, clr_en, state out.
module sb_entry
    import scoreboard_defs::*;
#(
    parameter int UNIT_W = DEF_UNIT_W,
    parameter int POS_W  = DEF_POS_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [UNIT_W-1:0] wr_unit,
    input  logic [POS_W-1:0]  wr_pos,
    input  logic              clr_en,
    output logic              pending,
    output logic [UNIT_W-1:0] unit,
    output logic [POS_W-1:0]  pos
);

    // An issue outranks a clear to the same register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pending <= 1'b0;
            unit    <= '0;
            pos     <= '0;
        end else if (wr_en) begin
            pending <= 1'b1;
            unit    <= wr_unit;
            pos     <= wr_pos;
        end else if (clr_en) begin
            pending <= 1'b0;
            unit    <= '0;
            pos     <= '0;
        end else begin
            pos <= pos >> 1;
        end
    end

endmodule

// File: rtl/scoreboard_mp.sv
// scoreboard_mp: multi-read-port register scoreboard with WAW / writeback-slot
// hazard checks and occupancy counter. Ports: clock, reset (sync, active-low),
// ass_addr/ass_data/rd_ready read ports, writeaddr/registerstage/writelatency/
// enablewrite issue, write_conflict, clearaddr/enableclear, busy_count.
// Optional macro SB_FORWARD_EN: ready on pos[0] and fwd_unit bypass select.
module scoreboard_mp
    import scoreboard_defs::*;
#(
    parameter int NUM_REGS       = 32,
    parameter int ADDR_W         = 5,
    parameter int NUM_READ_PORTS = 2,
    parameter int UNIT_W         = DEF_UNIT_W,
    parameter int POS_W          = DEF_POS_W,
    parameter int LAT_W          = 3,
    localparam int EW            = 1 + UNIT_W + POS_W
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_READ_PORTS*ADDR_W-1:0] ass_addr,
    output logic [NUM_READ_PORTS*EW-1:0]     ass_data,
    output logic [NUM_READ_PORTS-1:0]        rd_ready,
`ifdef SB_FORWARD_EN
    output logic [NUM_READ_PORTS*UNIT_W-1:0] fwd_unit,
`endif
    input  logic [ADDR_W-1:0]                writeaddr,
    input  logic [UNIT_W-1:0]                registerstage,
    input  logic [LAT_W-1:0]                 writelatency,
    input  logic                             enablewrite,
    output logic                             write_conflict,
    input  logic [ADDR_W-1:0]                clearaddr,
    input  logic                             enableclear,
    output logic [ADDR_W:0]                  busy_count
);

    logic [NUM_REGS-1:0] pend;
    logic [UNIT_W-1:0]   unit_q [NUM_REGS];
    logic [POS_W-1:0]    pos_q  [NUM_REGS];

    logic             lat_ok;
    logic             slot_hit;
    logic             accept;
    logic             dec;
    logic [POS_W-1:0] new_pos;
    logic [POS_W-1:0] slot_mask;

    // slot_mask selects bit L: an entry holding it shifts into bit L-1,
    // which is exactly where the new result would be placed.
    always_comb begin
        lat_ok    = (writelatency != '0) &&
                    (writelatency <= LAT_W'(POS_W));
        slot_mask = '0;
        if (writelatency < LAT_W'(POS_W))
            slot_mask = POS_W'(1) << writelatency;
        slot_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            slot_hit = slot_hit | (pend[i] & (|(pos_q[i] & slot_mask)));
        write_conflict = enablewrite &&
                         (!lat_ok || pend[writeaddr] || slot_hit);
        accept  = enablewrite && !write_conflict;
        new_pos = POS_W'(1) << (writelatency - LAT_W'(1));
        // A same-address clear can only meet an idle entry when accepted,
        // so pend[clearaddr] already yields the right net count.
        dec     = enableclear && pend[clearaddr];
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_ent
        sb_entry #(
            .UNIT_W(UNIT_W),
            .POS_W (POS_W)
        ) u_ent (
            .clock  (clock),
            .reset  (reset),
            .wr_en  (accept && (writeaddr == ADDR_W'(i))),
            .wr_unit(registerstage),
            .wr_pos (new_pos),
            .clr_en (enableclear && (clearaddr == ADDR_W'(i))),
            .pending(pend[i]),
            .unit   (unit_q[i]),
            .pos    (pos_q[i])
        );
    end

    for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = ass_addr[k*ADDR_W +: ADDR_W];
        assign ass_data[k*EW +: EW] = {pend[ra], unit_q[ra], pos_q[ra]};
`ifdef SB_FORWARD_EN
        logic fwd;
        assign fwd         = pend[ra] && pos_q[ra][0];
        assign rd_ready[k] = !pend[ra] || fwd;
        assign fwd_unit[k*UNIT_W +: UNIT_W] = fwd ? unit_q[ra] : '0;
`else
        assign rd_ready[k] = !pend[ra];
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset)
            busy_count <= '0;
        else
            busy_count <= busy_count + (ADDR_W+1)'(accept)
                                     - (ADDR_W+1)'(dec);
    end

endmodule

// File: doc/scoreboard_mp.md
Name: scoreboard_mp

Overview:
- Parametrised successor to the single-read-port register scoreboard.
- Tracks one entry per architectural register: pending bit, owning functional unit, and a one-hot result-position shift field that counts down to writeback.
- Adds N read ports, per-port operand-ready flags, issue-time hazard checks (WAW and writeback-slot collision), and an occupancy counter.
- Sits between decode/issue and the functional units; issue logic stalls on `write_conflict` or `!rd_ready`.

Parameters:
- NUM_REGS, 32, number of tracked registers (power of two, ≥2)
- ADDR_W, 5, register address width = clog2(NUM_REGS)
- NUM_READ_PORTS, 2, independent lookup ports (1..4)
- UNIT_W, 2, functional-unit tag width
- POS_W, 5, result-position field width = maximum issue latency in cycles
- LAT_W, 3, latency input width = clog2(POS_W+1)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- ass_addr  in  NUM_READ_PORTS*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- ass_data  out  NUM_READ_PORTS*(1+UNIT_W+POS_W)  packed entries {pending, unit, pos} per port
- rd_ready  out  NUM_READ_PORTS  operand k may be read this cycle
- writeaddr  in  ADDR_W  issue destination register
- registerstage  in  UNIT_W  issuing functional unit
- writelatency  in  LAT_W  cycles until result, legal 1..POS_W
- enablewrite  in  1  issue request
- write_conflict  out  1  issue refused this cycle
- clearaddr  in  ADDR_W  writeback register
- enableclear  in  1  writeback clear request
- busy_count  out  ADDR_W+1  number of pending entries

Behaviour:
- Reset: when reset==0 at a rising edge, all entries become {0, 0, 0} and busy_count becomes 0. ass_data, rd_ready (all 1) and write_conflict (0) follow combinationally.
- Reads: combinational from registered state; no same-cycle forwarding of an issue or clear.
- Conflict: write_conflict = enablewrite && (L==0 || L>POS_W || entry[writeaddr].pending || ∃ pending entry e with L<POS_W && e.pos[L]==1). The last term is a writeback-slot collision.
  - Shifted fields land at bit L-1 next cycle, the same slot the new entry would take.
- Issue accept: enablewrite && !write_conflict. Next cycle entry[writeaddr] = {1, registerstage, 1<<(L-1)}.
- Shift: every cycle, each entry not being written has pos <= pos>>1. Pending is unaffected by pos reaching 0.
- Clear: enableclear sets pending=0, unit=0, pos=0 on entry[clearaddr] next cycle. Clearing a non-pending entry is a no-op.
- Simultaneous accepted issue and clear:
  - Different address: both take effect.
  - Same address: the issue wins.
  - Because a pending destination always conflicts, same-address-accept can only occur when the entry is already idle.
- busy_count: +1 on an accepted issue, -1 on a clear of a pending entry. Both together cancel (net 0), except same address with issue winning: net +1 only if the entry was idle.
- Reset mid-operation: entries are discarded regardless of pending state; in-flight results are the issue logic's responsibility.
- rd_ready[k] = !entry[ass_addr_k].pending, or the SB_FORWARD_EN variant below.
- Duplicate addresses across read ports are legal and return identical data.

Optional Feature:
- Macro: SB_FORWARD_EN.
- Defined: rd_ready[k] also asserts when the entry is pending and pos[0]==1, meaning the result is on the bypass network next cycle. Adds forward output `fwd_unit` (NUM_READ_PORTS*UNIT_W) carrying the owning unit per port for bypass-mux select; this output is 0 when not forwarding.
- Undefined: rd_ready = !pending only; no fwd_unit port.

Decomposition:
- Shared package/header `scoreboard_defs`: entry field offsets (PEND_BIT, UNIT_LSB, POS_LSB), ENTRY_W = 1+UNIT_W+POS_W, functional-unit tag constants (ALU=0, MEM=1, MUL=2, BR=3).
- Sub-module `sb_entry`: one register entry with write/clear/shift logic and pending output, instantiated NUM_REGS times via generate.
- Read muxes, conflict reduction and busy counter live in the top level.

Test Plan:
- Reset: hold reset=0 for 1 edge, then read addresses 0 and 31 -> ass_data=0, rd_ready=2'b11, busy_count=0.
- Basic issue/shift/clear: issue r3, unit 1, L=4 -> ass_data pos 5'b01000, then 00100, 00010, 00001, 00000 on successive cycles, pending=1 throughout. Clear r3 -> pending 0, busy_count back to 0.
- WAW: issue r7 L=2, next cycle issue r7 L=3 -> write_conflict=1 and entry unchanged. After clear r7, the reissue is accepted.
- Slot collision: issue r1 L=3, next cycle issue r2 L=2 -> write_conflict=1 (r1 pos bit 2 set). Issue r2 L=3 instead -> accepted, r1 pos 00010 and r2 pos 00100.
- Simultaneous: with r4 pending, issue r5 L=1 and clear r4 in the same cycle -> r5 pending, r4 idle, busy_count unchanged. Also L=0 and L=6 each -> write_conflict=1.
- Forwarding (SB_FORWARD_EN): issue r9 unit 2 L=2; next cycle read r9 -> rd_ready=1 and fwd_unit=2 when pos=00001. Without the macro, rd_ready stays 0 until clear.
